// File: rtl/ps2_pkg.sv
// ps2_pkg: shared PS/2 definitions (states, result codes, command bytes, frame builder)
package ps2_pkg;
  typedef logic [2:0] ps2_state_t;
  localparam ps2_state_t PS2_ST_IDLE      = 3'd0;
  localparam ps2_state_t PS2_ST_INHIBIT   = 3'd1;
  localparam ps2_state_t PS2_ST_START     = 3'd2;
  localparam ps2_state_t PS2_ST_DATA      = 3'd3;
  localparam ps2_state_t PS2_ST_ACK       = 3'd4;
  localparam ps2_state_t PS2_ST_WAIT_IDLE = 3'd5;
  localparam ps2_state_t PS2_ST_DONE      = 3'd6;
  localparam logic [1:0] PS2_ERR_OK      = 2'b00;
  localparam logic [1:0] PS2_ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] PS2_ERR_NOACK   = 2'b10;
  localparam logic [1:0] PS2_ERR_STUCK   = 2'b11;
  localparam logic [7:0] PS2_CMD_SETLED = 8'hED;
  localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
  localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
  localparam logic [7:0] PS2_RSP_ACK    = 8'hFA;
  // shift-out order is bit 0 first: data LSB..MSB, odd parity, stop
  function automatic logic [9:0] ps2_frame(input logic [7:0] b);
    return {1'b1, ~^b, b};
  endfunction
endpackage

// File: rtl/ps2_sync_edge.sv
// ps2_sync_edge: 2-FF synchronizers for PS/2 clk/dat pins plus a registered falling-edge strobe on clk
//   clk, reset_n   system clock, asynchronous active-low reset
//   clk_in, dat_in raw asynchronous pin values
//   clk_s, dat_s   synchronized pin values (reset to idle-high)
//   clk_fall       one-cycle strobe when synchronized clk goes 1->0
module ps2_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic clk_in,
  input  logic dat_in,
  output logic clk_s,
  output logic dat_s,
  output logic clk_fall
);
  logic clk_m, dat_m, clk_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      {clk_m, clk_s, clk_d, dat_m, dat_s} <= '1;
      clk_fall <= 1'b0;
    end else begin
      clk_m <= clk_in;
      clk_s <= clk_m;
      clk_d <= clk_s;
      dat_m <= dat_in;
      dat_s <= dat_m;
      clk_fall <= clk_d & ~clk_s;
    end
endmodule

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (inhibit, start/data/parity/stop, ACK, timeouts)
//   clk, reset_n             system clock, asynchronous active-low reset
//   data_in, R_I             command byte and single-cycle request strobe (ignored while busy)
//   R_O, busy, err           completion strobe, busy flag, result code (held until next accept)
//   PS2_clk_in, PS2_dat_in   raw asynchronous pin values
//   PS2_clk_oe, PS2_dat_oe   1 pulls the corresponding open-drain line low
//   Define PS2_HOST_TX_RETRY_EN to retransmit once automatically after a timeout or missing ACK.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYC = 10000,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] data_in,
  input  logic       R_I,
  output logic       R_O,
  output logic       busy,
  output logic [1:0] err,
  input  logic       PS2_clk_in,
  input  logic       PS2_dat_in,
  output logic       PS2_clk_oe,
  output logic       PS2_dat_oe
);
  localparam int CW = $clog2((INHIBIT_CYC > TIMEOUT_CYC ? INHIBIT_CYC : TIMEOUT_CYC) + 1);
  ps2_state_t state;
  logic [9:0] frame;
  logic [3:0] bcnt;
  logic [CW-1:0] cnt;
  logic clk_s, dat_s, fall;
  logic timed_out, in_frame, fin;
  logic [1:0] code;
`ifdef PS2_HOST_TX_RETRY_EN
  logic [7:0] byte_q;
  logic retried;
`endif
  ps2_sync_edge u_sync (
    .clk(clk),
    .reset_n(reset_n),
    .clk_in(PS2_clk_in),
    .dat_in(PS2_dat_in),
    .clk_s(clk_s),
    .dat_s(dat_s),
    .clk_fall(fall)
  );
  // a falling edge in the expiry cycle takes priority over the timeout
  always_comb begin
    timed_out = cnt == CW'(TIMEOUT_CYC - 1);
    in_frame = state == PS2_ST_START || state == PS2_ST_DATA || state == PS2_ST_ACK;
    fin = (in_frame && !fall && timed_out) ||
          (state == PS2_ST_ACK && fall && dat_s) ||
          (state == PS2_ST_WAIT_IDLE && ((clk_s && dat_s) || timed_out));
    code = in_frame ? (fall ? PS2_ERR_NOACK : PS2_ERR_TIMEOUT) : (clk_s && dat_s ? PS2_ERR_OK : PS2_ERR_STUCK);
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= PS2_ST_IDLE;
      frame <= '0;
      bcnt <= '0;
      cnt <= '0;
      R_O <= 1'b0;
      busy <= 1'b0;
      err <= PS2_ERR_OK;
      PS2_clk_oe <= 1'b0;
      PS2_dat_oe <= 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
      byte_q <= '0;
      retried <= 1'b0;
`endif
    end else begin
      R_O <= 1'b0;
      cnt <= cnt + CW'(1);
`ifdef PS2_HOST_TX_RETRY_EN
      if (fin && !retried && (code[0] ^ code[1])) begin
        state <= PS2_ST_INHIBIT;
        frame <= ps2_frame(byte_q);
        bcnt <= '0;
        cnt <= '0;
        PS2_clk_oe <= 1'b1;
        PS2_dat_oe <= 1'b0;
        retried <= 1'b1;
      end else
`endif
      if (fin) begin
        state <= PS2_ST_DONE;
        R_O <= 1'b1;
        busy <= 1'b0;
        err <= code;
        PS2_clk_oe <= 1'b0;
        PS2_dat_oe <= 1'b0;
      end else
        case (state)
          PS2_ST_IDLE, PS2_ST_DONE: begin
            state <= R_I ? PS2_ST_INHIBIT : PS2_ST_IDLE;
            if (R_I) begin
              frame <= ps2_frame(data_in);
              bcnt <= '0;
              cnt <= '0;
              busy <= 1'b1;
              PS2_clk_oe <= 1'b1;
`ifdef PS2_HOST_TX_RETRY_EN
              byte_q <= data_in;
              retried <= 1'b0;
`endif
            end
          end
          PS2_ST_INHIBIT: begin
            if (cnt == CW'(INHIBIT_CYC - 2))
              PS2_dat_oe <= 1'b1;
            if (cnt == CW'(INHIBIT_CYC - 1)) begin
              state <= PS2_ST_START;
              cnt <= '0;
              PS2_clk_oe <= 1'b0;
            end
          end
          PS2_ST_START, PS2_ST_DATA:
            if (fall) begin
              PS2_dat_oe <= ~frame[0];
              frame <= {1'b1, frame[9:1]};
              bcnt <= bcnt + 4'd1;
              cnt <= '0;
              state <= bcnt == 4'd9 ? PS2_ST_ACK : PS2_ST_DATA;
            end
          PS2_ST_ACK:
            if (fall) begin
              state <= PS2_ST_WAIT_IDLE;
              cnt <= '0;
            end
          PS2_ST_WAIT_IDLE: ;
          default: state <= PS2_ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: scoreboard bench for ps2_host_tx with a behavioural PS/2 device model
module tb_ps2_host_tx;
  localparam int INH = 40;
  localparam int TMO = 3000;
  localparam int HALF = 200;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic R_I = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic R_O, busy;
  logic [1:0] err;
  logic PS2_clk_oe, PS2_dat_oe;
  logic dev_clk = 1'b1;
  logic dev_dat = 1'b1;
  logic clk_line, dat_line;
  int tests = 0, fails = 0, ro_cnt = 0, dev_edges = 0, stop_after = 0, w = 0, last_w = 0;
  bit ack_en = 1'b1;
  bit abort = 1'b0;
  logic [1:0] exp_err_q[$];
  logic [10:0] exp_frame_q[$];
  assign clk_line = dev_clk & ~PS2_clk_oe;
  assign dat_line = dev_dat & ~PS2_dat_oe;
  ps2_host_tx #(.INHIBIT_CYC(INH), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .data_in(data_in),
    .R_I(R_I),
    .R_O(R_O),
    .busy(busy),
    .err(err),
    .PS2_clk_in(clk_line),
    .PS2_dat_in(dat_line),
    .PS2_clk_oe(PS2_clk_oe),
    .PS2_dat_oe(PS2_dat_oe)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (R_O) begin
      ro_cnt++;
      if (exp_err_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_ro: got R_O with err %0d expected no R_O", err);
      end else begin
        chk("err", err, exp_err_q.pop_front());
        chk("busy_at_ro", busy, 0);
      end
    end
    if (PS2_clk_oe) w++;
    else if (w != 0) begin
      last_w = w;
      w = 0;
    end
  end
  initial begin : device
    logic [10:0] bits;
    int n;
    forever begin
      wait (PS2_clk_oe === 1'b1);
      wait (PS2_clk_oe === 1'b0);
      dev_edges = 0;
      n = 0;
      bits = '0;
      #2;
      #(HALF);
      bits[0] = dat_line;
      for (int i = 1; i <= 11; i++) begin
        if (abort) break;
        dev_clk = 1'b0;
        dev_edges = i;
        #(HALF);
        if (stop_after == i || abort) break;
        if (i <= 10) bits[i] = dat_line;
        dev_clk = 1'b1;
        if (i == 10 && ack_en) dev_dat = 1'b0;
        if (i == 11) dev_dat = 1'b1;
        n = i;
        #(HALF);
      end
      dev_clk = 1'b1;
      dev_dat = 1'b1;
      if (n == 11) begin
        if (exp_frame_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_frame: got %0h expected no frame", bits);
        end else chk("frame", bits, exp_frame_q.pop_front());
      end
    end
  end
  task automatic issue(input logic [7:0] b);
    @(posedge clk);
    #1;
    data_in = b;
    R_I = 1'b1;
    @(posedge clk);
    #1;
    R_I = 1'b0;
    chk("busy_rise", busy, 1);
    chk("clk_oe_rise", PS2_clk_oe, 1);
  endtask
  task automatic wait_ro(input int n0, input string nm, output int k);
    k = 0;
    while (ro_cnt == n0 && k < 10000) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk({nm, "_ro_count"}, ro_cnt - n0, 1);
  endtask
  task automatic wait_edges(input int n);
    int k = 0;
    while (dev_edges < n && k < 5000) begin
      @(posedge clk);
      k++;
    end
    chk("edges_reached", dev_edges >= n, 1);
  endtask
  task automatic req(input logic [7:0] b, input logic par, input logic [1:0] e, input int frames, input string nm, output int k);
    int n0;
    for (int f = 0; f < frames; f++) exp_frame_q.push_back({1'b1, par, b, 1'b0});
    exp_err_q.push_back(e);
    n0 = ro_cnt;
    issue(b);
    wait_ro(n0, nm, k);
  endtask
  initial begin : main
    int n0, k;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("rst_ro", R_O, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_clk_oe", PS2_clk_oe, 0);
    chk("rst_dat_oe", PS2_dat_oe, 0);
    reset_n = 1'b1;
    repeat (3) @(posedge clk);
    req(8'hED, 1'b1, 2'b00, 1, "setled", k);
    req(8'hF4, 1'b0, 2'b00, 1, "enable", k);
    chk("inhibit_width", last_w, INH);
    ack_en = 1'b0;
`ifdef PS2_HOST_TX_RETRY_EN
    req(8'h01, 1'b0, 2'b10, 2, "noack", k);
`else
    req(8'h01, 1'b0, 2'b10, 1, "noack", k);
`endif
    ack_en = 1'b1;
    repeat (50) @(posedge clk);
    stop_after = 4;
    req(8'h80, 1'b0, 2'b01, 0, "timeout", k);
    chk("timeout_clk_oe", PS2_clk_oe, 0);
    chk("timeout_dat_oe", PS2_dat_oe, 0);
`ifndef PS2_HOST_TX_RETRY_EN
    chk("timeout_latency_in_window", k >= 3150 && k <= 3230, 1);
`endif
    n0 = ro_cnt;
    repeat (200) @(posedge clk);
    chk("timeout_single_ro", ro_cnt - n0, 0);
    chk("err_held", err, 2'b01);
    stop_after = 0;
    exp_frame_q.push_back({1'b1, 1'b1, 8'h5A, 1'b0});
    exp_err_q.push_back(2'b00);
    n0 = ro_cnt;
    issue(8'h5A);
    wait_edges(3);
    @(posedge clk);
    #1;
    data_in = 8'h00;
    R_I = 1'b1;
    @(posedge clk);
    #1;
    R_I = 1'b0;
    chk("busy_mid_ri", busy, 1);
    wait_ro(n0, "mid_ri", k);
    repeat (50) @(posedge clk);
    n0 = ro_cnt;
    issue(8'h00);
    wait_edges(5);
    #3;
    abort = 1'b1;
    reset_n = 1'b0;
    #1;
    chk("rst_mid_clk_oe", PS2_clk_oe, 0);
    chk("rst_mid_dat_oe", PS2_dat_oe, 0);
    chk("rst_mid_busy", busy, 0);
    #(2 * HALF + 20);
    reset_n = 1'b1;
    abort = 1'b0;
    repeat (5) @(posedge clk);
    chk("rst_mid_no_ro", ro_cnt - n0, 0);
    req(8'hFF, 1'b1, 2'b00, 1, "reset_cmd", k);
    repeat (60) @(posedge clk);
    chk("err_q_empty", exp_err_q.size(), 0);
    chk("frame_q_empty", exp_frame_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
